// File: rtl/mips_pkg.sv
// Shared definitions for the fetch side of the MIPS core: word width,
// the NOP encoding returned on faults, the responder state encoding and
// the address decode helpers.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  // Word index of a byte address relative to the memory base.
  // Unsigned 32-bit subtract; addresses below base wrap to a huge index.
  function automatic logic [31:0] word_index(input logic [31:0] addr,
                                             input logic [31:0] base);
    logic [31:0] off_v;
    off_v = addr - base;
    word_index = off_v >> 2;
  endfunction

  // Fault when the address is misaligned, below base, or past the last word.
  // The explicit below-base term keeps wrapped addresses from aliasing.
  function automatic logic addr_fault(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] depth);
    logic [31:0] idx_v;
    idx_v = word_index(addr, base);
    addr_fault = (addr[1:0] != 2'b00) || (addr < base) || (idx_v >= depth);
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: DEPTH x 32-bit register array, written only through
// the preload port and read combinationally by word index. Contents are
// deliberately not reset so a program survives a core reset.
module imem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = 6
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [WORD_W-1:0] mem_r [DEPTH];
  logic              wr_in_range_s;
  logic              rd_in_range_s;

  // Range qualification of write and read indices.
  always_comb begin
    wr_in_range_s = ({{(32-IDX_W){1'b0}}, wr_idx} < DEPTH_W);
    rd_in_range_s = ({{(32-IDX_W){1'b0}}, rd_idx} < DEPTH_W);
  end

  // Preload write; out-of-range indices are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range_s) begin
      mem_r[wr_idx] <= wr_data;
    end
  end

  // Combinational read; out-of-range reads return a NOP.
  always_comb begin
    rd_data = NOP_WORD;
    if (rd_in_range_s) begin
      rd_data = mem_r[rd_idx];
    end else begin
      rd_data = NOP_WORD;
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: accepts one fetch address at a time,
// captures the word (or fault) at accept, waits a fixed latency and then
// presents the result on a valid/ready response channel.
module imem_responder
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0010,
  parameter int          DEPTH     = 64,
  parameter int          LATENCY   = 2,
  parameter int          IDX_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [IDX_W-1:0]  load_idx,
  input  logic [WORD_W-1:0] load_data
);

  localparam logic [31:0] DEPTH_W  = 32'(DEPTH);
  localparam logic        LAT_ZERO = (LATENCY == 0);
  localparam logic [3:0]  LAT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  resp_state_e       state_r;
  logic [3:0]        cnt_r;
  logic              req_ready_r;
  logic              rsp_valid_r;
  logic [WORD_W-1:0] rsp_data_r;
  logic              rsp_err_r;

  logic              accept_s;
  logic              fault_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [WORD_W-1:0] rd_data_s;

  assign req_ready = req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign rsp_err   = rsp_err_r;

  // Address decode and accept qualification for the current request.
  always_comb begin
    accept_s = req_valid && req_ready_r && (state_r == IDLE);
    fault_s  = addr_fault(req_addr, BASE_ADDR, DEPTH_W);
    rd_idx_s = IDX_W'(word_index(req_addr, BASE_ADDR));
  end

  imem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (load_en),
    .wr_idx  (load_idx),
    .wr_data (load_data),
    .rd_idx  (rd_idx_s),
    .rd_data (rd_data_s)
  );

  // Handshake FSM with latency counter; all outputs are registered.
  // RESP spends one edge raising rsp_valid, so the response appears
  // LATENCY+1 edges after accept; req_ready reasserts one edge after
  // the response handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= NOP_WORD;
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            req_ready_r <= 1'b0;
            rsp_err_r   <= fault_s;
            rsp_data_r  <= fault_s ? NOP_WORD : rd_data_s;
            if (LAT_ZERO) begin
              state_r <= RESP;
              cnt_r   <= 4'd0;
            end else begin
              state_r <= WAIT;
              cnt_r   <= LAT_INIT;
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd0) begin
            state_r <= RESP;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (!rsp_valid_r) begin
            rsp_valid_r <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            rsp_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 4'd0;
          req_ready_r <= 1'b0;
          rsp_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
